// File: rtl/mod_counter_updown.sv
// Parametrised up/down counter with programmable modulo, parallel load,
// wrap/saturate modes, combinational terminal count and a sticky wrap flag.
module mod_counter_updown #(
  parameter int WIDTH  = 3,
  parameter int MODULO = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_wrap,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
);

  // One extra bit so MODULO = 2^WIDTH and the borrow out of zero are representable.
  localparam logic [WIDTH:0] MOD_X  = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH:0] LAST_X = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);

  logic [WIDTH-1:0] count_reg, count_next;
  logic             wrapped_reg, wrapped_next;
  logic [WIDTH:0]   count_ext, load_ext, inc_ext, dec_ext;
  logic             at_last, at_zero, at_end, wrap_event;

  always_comb begin
    count_ext = {1'b0, count_reg};
    load_ext  = {1'b0, load_val};
    inc_ext   = count_ext + ONE_X;
    dec_ext   = count_ext - ONE_X;
    at_last   = (inc_ext == MOD_X);
    at_zero   = dec_ext[WIDTH];
    at_end    = up ? at_last : at_zero;
  end

  always_comb begin
    count_next = count_reg;
    wrap_event = 1'b0;
    if (load) begin
      // Out-of-range load values clamp to the top of the range.
      count_next = (load_ext > LAST_X) ? LAST_X[WIDTH-1:0] : load_val;
    end else if (en) begin
      if (at_end) begin
        if (!sat) begin
          wrap_event = 1'b1;
          count_next = up ? '0 : LAST_X[WIDTH-1:0];
        end
      end else begin
        count_next = up ? inc_ext[WIDTH-1:0] : dec_ext[WIDTH-1:0];
      end
    end
    wrapped_next = wrap_event | (wrapped_reg & ~clr_wrap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg   <= '0;
      wrapped_reg <= 1'b0;
    end else begin
      count_reg   <= count_next;
      wrapped_reg <= wrapped_next;
    end
  end

  assign count   = count_reg;
  assign wrapped = wrapped_reg;
  assign tc      = en & ~load & at_end;

endmodule

// File: tb/tb_mod_counter_updown.sv
// Bench for mod_counter_updown: four instances (moduli 8, 5, 6 and 16) share one
// stimulus stream; a reference model feeds a scoreboard queue checked after each edge.
module tb_mod_counter_updown;

  logic       clk = 1'b0;
  logic       rst, en, up, sat, load, clr_wrap;
  logic [3:0] load_val;

  logic [2:0] count8, count5, count6;
  logic [3:0] count16;
  logic       tc8, tc5, tc6, tc16;
  logic       wrapped8, wrapped5, wrapped6, wrapped16;

  always #5 clk = ~clk;

  mod_counter_updown #(.WIDTH(3), .MODULO(8)) u_m8 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val[2:0]), .clr_wrap(clr_wrap),
    .count(count8), .tc(tc8), .wrapped(wrapped8));
  mod_counter_updown #(.WIDTH(3), .MODULO(5)) u_m5 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val[2:0]), .clr_wrap(clr_wrap),
    .count(count5), .tc(tc5), .wrapped(wrapped5));
  mod_counter_updown #(.WIDTH(3), .MODULO(6)) u_m6 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val[2:0]), .clr_wrap(clr_wrap),
    .count(count6), .tc(tc6), .wrapped(wrapped6));
  mod_counter_updown #(.WIDTH(4), .MODULO(16)) u_m16 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .clr_wrap(clr_wrap),
    .count(count16), .tc(tc16), .wrapped(wrapped16));

  typedef struct {
    int idx;
    int cnt;
    bit wr;
  } exp_t;

  typedef struct {
    bit r, e, u, s, l;
    int lv;
    bit cw;
    int ec;
    bit ew;
    bit etc;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  int mod_of[4]  = '{8, 5, 6, 16};
  int bits_of[4] = '{3, 3, 3, 4};
  int mc[4];
  bit mw[4];
  int n_total = 0;
  int n_pass  = 0;
  int n_step  = 0;

  function automatic int dut_count(int i);
    case (i)
      0:       return int'(count8);
      1:       return int'(count5);
      2:       return int'(count6);
      default: return int'(count16);
    endcase
  endfunction

  function automatic bit dut_tc(int i);
    case (i)
      0:       return tc8;
      1:       return tc5;
      2:       return tc6;
      default: return tc16;
    endcase
  endfunction

  function automatic bit dut_wrapped(int i);
    case (i)
      0:       return wrapped8;
      1:       return wrapped5;
      2:       return wrapped6;
      default: return wrapped16;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // One clock transaction: drive, check tc, push model results, clock, pop and compare.
  task automatic step(input bit r, e, u, s, l, input int lv, input bit cw,
                      input bit have_exp = 1'b0, input int ec = 0,
                      input bit ew = 1'b0, input bit etc = 1'b0);
    exp_t x;
    rst = r; en = e; up = u; sat = s; load = l; load_val = 4'(lv); clr_wrap = cw;
    #1;
    for (int i = 0; i < 4; i++) begin
      int m, c, lvm, nc;
      bit w, ev, mtc;
      m   = mod_of[i];
      c   = mc[i];
      w   = mw[i];
      lvm = lv & ((1 << bits_of[i]) - 1);
      mtc = e && !l && (u ? (c == m - 1) : (c == 0));
      if (!r) chk($sformatf("tc_m%0d", m), int'(dut_tc(i)), int'(mtc));
      ev = 1'b0;
      nc = c;
      if (r) begin
        nc = 0;
        w  = 1'b0;
      end else begin
        if (l) nc = (lvm > m - 1) ? m - 1 : lvm;
        else if (e && u) begin
          if (c < m - 1) nc = c + 1;
          else if (!s) begin nc = 0; ev = 1'b1; end
        end else if (e && !u) begin
          if (c > 0) nc = c - 1;
          else if (!s) begin nc = m - 1; ev = 1'b1; end
        end
        if (ev) w = 1'b1;
        else if (cw) w = 1'b0;
      end
      mc[i] = nc;
      mw[i] = w;
      sb.push_back('{idx: i, cnt: nc, wr: w});
    end
    if (have_exp && !r) chk("tbl_tc_m8", int'(tc8), int'(etc));
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      chk($sformatf("count_m%0d", mod_of[x.idx]), dut_count(x.idx), x.cnt);
      chk($sformatf("wrapped_m%0d", mod_of[x.idx]), int'(dut_wrapped(x.idx)), int'(x.wr));
    end
    if (have_exp) begin
      chk("tbl_count_m8", int'(count8), ec);
      chk("tbl_wrapped_m8", int'(wrapped8), int'(ew));
    end
    $display("step %0d rst=%0b en=%0b up=%0b sat=%0b load=%0b lv=%0d clr=%0b -> m8=%0d/%0b m5=%0d/%0b m6=%0d/%0b m16=%0d/%0b",
             n_step, r, e, u, s, l, lv, cw, count8, wrapped8, count5, wrapped5,
             count6, wrapped6, count16, wrapped16);
    n_step++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0;
    load_val = '0; clr_wrap = 1'b0;
    for (int i = 0; i < 4; i++) begin mc[i] = 0; mw[i] = 1'b0; end

    // Expected values here are for the modulo-8 instance: r e u s l lv cw count wrapped tc
    tbl.push_back('{1,0,1,0,0,0,0, 0,0,0});
    for (int k = 1; k <= 10; k++)
      tbl.push_back('{0,1,1,0,0,0,0, k % 8, (k >= 8), (k == 8)});
    tbl.push_back('{0,0,1,0,0,0,1, 2,0,0});
    tbl.push_back('{0,0,1,0,1,7,0, 7,0,0});
    tbl.push_back('{0,1,1,0,0,0,1, 0,1,1});
    tbl.push_back('{0,1,1,0,0,0,0, 1,1,0});
    tbl.push_back('{0,1,1,0,0,0,0, 2,1,0});
    for (int k = 0; k < 3; k++)
      tbl.push_back('{1,1,1,0,1,3,0, 0,0,0});
    tbl.push_back('{0,1,1,0,0,0,0, 1,0,0});
    tbl.push_back('{0,1,1,0,0,0,0, 2,0,0});

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].r, tbl[i].e, tbl[i].u, tbl[i].s, tbl[i].l, tbl[i].lv, tbl[i].cw,
           1'b1, tbl[i].ec, tbl[i].ew, tbl[i].etc);

    // Modulo 5 count-down through zero, then clear the sticky flag.
    step(0,0,1,0,1,1,0);
    chk("t2_load_m5", int'(count5), 1);
    step(0,1,0,0,0,0,0);
    chk("t2_cnt0_m5", int'(count5), 0);
    en = 1'b1; up = 1'b0; sat = 1'b0; load = 1'b0; clr_wrap = 1'b0;
    #1;
    chk("t2_tc_at0_m5", int'(tc5), 1);
    step(0,1,0,0,0,0,0);
    chk("t2_cnt4_m5", int'(count5), 4);
    chk("t2_wrap_m5", int'(wrapped5), 1);
    step(0,1,0,0,0,0,0);
    chk("t2_cnt3_m5", int'(count5), 3);
    step(0,0,0,0,0,0,1);
    chk("t2_clr_m5", int'(wrapped5), 0);

    // Modulo 6 saturating at the top, then reversing direction.
    step(0,0,1,1,1,4,0);
    for (int k = 0; k < 3; k++) begin
      step(0,1,1,1,0,0,0);
      chk("t3_sat_m6", int'(count6), 5);
      chk("t3_nowrap_m6", int'(wrapped6), 0);
    end
    step(0,1,0,1,0,0,0);
    chk("t3_down4_m6", int'(count6), 4);
    step(0,1,0,1,0,0,0);
    chk("t3_down3_m6", int'(count6), 3);

    // Load clamp, then load overriding an enabled count.
    step(0,0,1,0,1,7,0);
    chk("t4_clamp_m6", int'(count6), 5);
    en = 1'b1; up = 1'b1; sat = 1'b0; load = 1'b1; load_val = 4'd2; clr_wrap = 1'b0;
    #1;
    chk("t4_tc_load_m6", int'(tc6), 0);
    step(0,1,1,0,1,2,0);
    chk("t4_load_m6", int'(count6), 2);

    // Full-range 4-bit counter: wrap up from 15 and down from 0.
    step(0,0,1,0,0,0,1);
    step(0,0,1,0,1,15,0);
    chk("t6_load_m16", int'(count16), 15);
    step(0,1,1,0,0,0,0);
    chk("t6_upwrap_m16", int'(count16), 0);
    chk("t6_upflag_m16", int'(wrapped16), 1);
    step(0,0,1,0,0,0,1);
    chk("t6_clr_m16", int'(wrapped16), 0);
    step(0,1,0,0,0,0,0);
    chk("t6_dnwrap_m16", int'(count16), 15);
    chk("t6_dnflag_m16", int'(wrapped16), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mod_counter_updown.md
Name: mod_counter_updown

Overview:
- Parametrised registered up/down counter that generalises the team's fixed 3-bit next-state incrementer.
- Adds:
  - programmable modulo
  - count enable and direction
  - synchronous parallel load
  - wrap or saturate mode
  - terminal-count output
  - sticky wrap flag
- Used as the state/sequence counter feeding condition-decoding logic in the FSD project blocks.

Parameters:
- WIDTH, 3, counter width in bits; must be ≥1.
- MODULO, 8, count range 0..MODULO-1; 2 ≤ MODULO ≤ 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- sat  input  1  mode: 1 = saturate at ends, 0 = wrap modulo MODULO.
- load  input  1  synchronous parallel load request.
- load_val  input  WIDTH  value to load.
- clr_wrap  input  1  clears the sticky wrap flag.
- count  output  WIDTH  registered counter value.
- tc  output  1  combinational terminal count: en & ~load & at end in current direction.
- wrapped  output  1  registered sticky flag, set whenever a wrap occurs.

Behaviour:
- Reset:
  - Synchronous, active-high, one clock (clk).
  - On a rising clk edge with rst=1: count=0, wrapped=0.
  - rst overrides all other inputs.
- Priority per edge: rst > load > en. With en=0 and load=0, count holds.
- Load:
  - count <= load_val if load_val ≤ MODULO-1.
  - Otherwise count <= MODULO-1 (clamp).
  - Load ignores en, up and sat, and never sets wrapped.
- Count, en=1, up=1:
  - count < MODULO-1: count+1.
  - count = MODULO-1 and sat=0: count <= 0, wrapped <= 1.
  - count = MODULO-1 and sat=1: hold at MODULO-1; wrapped unchanged.
- Count, en=1, up=0:
  - count > 0: count-1.
  - count = 0 and sat=0: count <= MODULO-1, wrapped <= 1.
  - count = 0 and sat=1: hold at 0.
- Arithmetic:
  - Computed in WIDTH+1 bits internally, so MODULO = 2^WIDTH wraps correctly with no overflow artefacts.
  - count must never hold a value ≥ MODULO.
- tc:
  - High in the same cycle as the edge that will wrap or saturate:
    - up=1 and count=MODULO-1, or
    - up=0 and count=0,
    - with en=1 and load=0.
  - tc is asserted in sat mode too.
  - tc does not depend on rst. The bench checks tc only while rst=0.
- wrapped:
  - Set by a wrap event.
  - Cleared on the edge where clr_wrap=1.
  - Simultaneous wrap and clr_wrap: set wins (wrapped=1).
- Direction change mid-count: takes effect on the next enabled edge. No extra latency and no hidden state.
- Latency: count updates one edge after the inputs are sampled. tc is zero-latency combinational.
- Reset asserted mid-count: next edge forces count=0 and wrapped=0, regardless of en, load or clr_wrap.
- No internal state beyond count and wrapped. Simulation must produce no X on any output after the first reset edge.

Test Plan:
1. Reset, then en=1, up=1, sat=0 for 10 cycles (WIDTH=3, MODULO=8):
   - count = 1,2,…,7,0,1,2.
   - tc=1 only while count=7.
   - wrapped=1 from the edge count went 7→0.
2. MODULO=5, WIDTH=3, en=1, up=0, sat=0 from count=1:
   - count = 0,4,3.
   - tc high at count=0.
   - wrapped set.
   - Then clr_wrap=1 for one cycle → wrapped=0.
3. sat=1, up=1, MODULO=6, loaded to 4:
   - count = 5,5,5; wrapped stays 0.
   - Switch up=0 → count = 4,3.
4. load=1 with load_val=7 and MODULO=6:
   - count=5 (clamped).
   - Then load=1 and en=1 with load_val=2 → count=2, en ignored, tc=0 in that cycle.
5. Wrap event coincident with clr_wrap=1 (count=7, up=1, en=1, sat=0):
   - count=0, wrapped=1.
6. Mid-count, assert rst with load=1, load_val=3, en=1:
   - count=0, wrapped=0 after the edge.
   - With rst held 3 cycles, count stays 0.
   - Release rst → counting resumes 1,2.
   - Also run WIDTH=4, MODULO=16: 15→0 wrap, 0→15 down-wrap.
